// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully-connected layer engine.
// Holds the FSM state encoding, accumulator sizing and the shift/saturate helper.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    BIAS,
    MAC,
    EMIT,
    DONE
  } fc_state_t;

  // Default Q8.8 format constants.
  localparam int FRAC = 8;
  localparam int ONE  = 1 << FRAC;

  // Container width for sat_shift; must be at least the widest accumulator used.
  localparam int SAT_W = 64;

  // Wide enough that IP_SIZE full-scale products plus a shifted bias never overflow.
  function automatic int acc_width(input int word, input int ip);
    return 2 * word + $clog2(ip) + 1;
  endfunction

  // Arithmetic shift right by frac (floor), then clamp to a signed word-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac,
    input int                      word
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (word - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (word - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/fc_layer_engine_mac.sv
// Signed multiply-accumulate datapath: accumulator with clear / load-bias / accumulate
// controls and a combinational shift, saturate and optional ReLU output.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int FRAC_W    = 8,
  parameter int ACC_W     = 40,
  parameter int RELU_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load_bias,
  input  logic                 accumulate,
  input  logic [WORD_SIZE-1:0] x_word,
  input  logic [WORD_SIZE-1:0] w_word,
  output logic [WORD_SIZE-1:0] z
);

  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       bias_ext;
  logic signed [2*WORD_SIZE-1:0] prod;

  assign prod = $signed(x_word) * $signed(w_word);

  // The bias is a plain Q word; shifting it by FRAC_W puts it on the product scale.
  assign bias_ext = ACC_W'($signed(w_word)) <<< FRAC_W;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (load_bias) begin
      acc <= bias_ext;
    end else if (accumulate) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // A negative accumulator always floors to a negative word, so its sign bit drives ReLU.
  always_comb begin
    z = WORD_SIZE'(sat_shift(SAT_W'(acc), FRAC_W, WORD_SIZE));
    if ((RELU_EN != 0) && acc[ACC_W-1]) begin
      z = '0;
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer computed one neuron at a time on a single MAC, with a buffered
// input vector, streamed bias/weights, valid/ready output stream and running argmax.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int INT_SLICE = 8,
  parameter int IP_SIZE   = 128,
  parameter int OP_SIZE   = 84,
  parameter int RELU_EN   = 1,
  parameter int IDX_W     = $clog2(OP_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 x_valid,
  input  logic [WORD_SIZE-1:0] x_data,
  output logic                 x_ready,
  input  logic                 w_valid,
  input  logic [WORD_SIZE-1:0] w_data,
  output logic                 w_ready,
  output logic                 z_valid,
  output logic [WORD_SIZE-1:0] z_data,
  output logic [IDX_W-1:0]     z_index,
  input  logic                 z_ready,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     argmax
);

  // Handshake rule on every stream: a word transfers on a rising clk edge where
  // valid and ready are both high; a source holds valid/data until that edge.

  localparam int FRAC_W = WORD_SIZE - INT_SLICE;
  localparam int ACC_W  = acc_width(WORD_SIZE, IP_SIZE);
  localparam int KW     = (IP_SIZE > 1) ? $clog2(IP_SIZE) : 1;
  localparam logic [KW-1:0]    K_LAST = KW'(IP_SIZE - 1);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(OP_SIZE - 1);

  fc_state_t state;
  fc_state_t state_d;

  logic [KW-1:0]               k;
  logic [IDX_W-1:0]            n;
  logic [WORD_SIZE-1:0]        x_buf [IP_SIZE];
  logic signed [WORD_SIZE-1:0] best;
  logic                        x_hs;
  logic                        w_hs;
  logic                        z_hs;

  assign x_hs    = x_valid & x_ready;
  assign w_hs    = w_valid & w_ready;
  assign z_hs    = z_valid & z_ready;
  assign z_index = n;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = LOAD_X;
      LOAD_X:  if (x_hs && (k == K_LAST)) state_d = BIAS;
      BIAS:    if (w_hs) state_d = MAC;
      MAC:     if (w_hs && (k == K_LAST)) state_d = EMIT;
      EMIT:    if (z_hs) state_d = (n == N_LAST) ? DONE : BIAS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x_ready <= 1'b0;
      w_ready <= 1'b0;
      z_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      k       <= '0;
      n       <= '0;
      argmax  <= '0;
      best    <= '0;
    end else begin
      state   <= state_d;
      x_ready <= (state_d == LOAD_X);
      w_ready <= (state_d == BIAS) || (state_d == MAC);
      z_valid <= (state_d == EMIT);
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            k <= '0;
            n <= '0;
          end
        end
        LOAD_X: if (x_hs) k <= k + 1'b1;
        BIAS:   if (w_hs) k <= '0;
        MAC:    if (w_hs) k <= k + 1'b1;
        EMIT: begin
          if (z_hs) begin
            // Strict compare keeps the lower index on ties.
            if ((n == '0) || ($signed(z_data) > best)) begin
              argmax <= n;
              best   <= $signed(z_data);
            end
            if (n != N_LAST) n <= n + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (x_hs) x_buf[k] <= x_data;
  end

  fc_mac_unit #(
    .WORD_SIZE (WORD_SIZE),
    .FRAC_W    (FRAC_W),
    .ACC_W     (ACC_W),
    .RELU_EN   (RELU_EN)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .clear      ((state == IDLE) && start),
    .load_bias  ((state == BIAS) && w_hs),
    .accumulate ((state == MAC) && w_hs),
    .x_word     (x_buf[k]),
    .w_word     (w_data),
    .z          (z_data)
  );

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: IP=4, OP=3, Q8.8, with ReLU-on and ReLU-off
// instances driven in lockstep from the same streams.
module tb_fc_layer_engine;
  localparam int W     = 16;
  localparam int IP    = 4;
  localparam int OP    = 3;
  localparam int IDX_W = 2;
  localparam int W_LEN = OP * (IP + 1);
  localparam int TOTAL_CYC = 1 + IP + OP * (IP + 2) + 1;

  logic clk = 1'b0;
  logic rst, start, x_valid, w_valid, z_ready;
  logic [W-1:0] x_data, w_data;
  logic x_ready, w_ready, z_valid, busy, done;
  logic [W-1:0] z_data;
  logic [IDX_W-1:0] z_index, argmax;
  logic x_ready_nr, w_ready_nr, z_valid_nr, busy_nr, done_nr;
  logic [W-1:0] z_data_nr;
  logic [IDX_W-1:0] z_index_nr, argmax_nr;

  logic [W-1:0] x_vec [IP];
  logic [W-1:0] w_vec [W_LEN];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_nr_q[$];
  logic [IDX_W-1:0] idx_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_layer_engine #(.WORD_SIZE(W), .INT_SLICE(8), .IP_SIZE(IP), .OP_SIZE(OP), .RELU_EN(1))
  dut (.clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
       .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready), .z_valid(z_valid), .z_data(z_data),
       .z_index(z_index), .z_ready(z_ready), .busy(busy), .done(done), .argmax(argmax));

  fc_layer_engine #(.WORD_SIZE(W), .INT_SLICE(8), .IP_SIZE(IP), .OP_SIZE(OP), .RELU_EN(0))
  dut_nr (.clk(clk), .rst(rst), .start(start), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready_nr),
          .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_nr), .z_valid(z_valid_nr), .z_data(z_data_nr),
          .z_index(z_index_nr), .z_ready(z_ready), .busy(busy_nr), .done(done_nr), .argmax(argmax_nr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_x(input logic [W-1:0] a, b, c, d);
    x_vec[0] = a; x_vec[1] = b; x_vec[2] = c; x_vec[3] = d;
  endtask

  task automatic set_n(input int n, input logic [W-1:0] bias, w0, w1, w2, w3);
    w_vec[n*5]   = bias;
    w_vec[n*5+1] = w0;
    w_vec[n*5+2] = w1;
    w_vec[n*5+3] = w2;
    w_vec[n*5+4] = w3;
  endtask

  task automatic push_exp(input logic [W-1:0] r0, r1, r2, q0, q1, q2);
    exp_q.push_back(r0); exp_q.push_back(r1); exp_q.push_back(r2);
    exp_nr_q.push_back(q0); exp_nr_q.push_back(q1); exp_nr_q.push_back(q2);
    idx_q.push_back(2'd0); idx_q.push_back(2'd1); idx_q.push_back(2'd2);
  endtask

  task automatic load_basic();
    set_x(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    set_n(0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
    set_n(1, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
    set_n(2, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0000);
    push_exp(16'h0100, 16'h0480, 16'h0180, 16'h0100, 16'h0480, 16'h0180);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x_ready"}, x_ready, 0);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_z_valid"}, z_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_z_data"}, z_data, 0);
    check({tag, "_z_index"}, z_index, 0);
    check({tag, "_argmax"}, argmax, 0);
  endtask

  // One inference; called and returning at a negedge.
  task automatic run(input bit gaps, input int stall_n, input int extra_start, input int abort_cyc,
                     input logic [IDX_W-1:0] exp_arg, input logic [IDX_W-1:0] exp_arg_nr,
                     input int exp_cycles);
    int xi, wi, cyc, stall_left;
    bit fin, stall_done, x_hs, w_hs;
    xi = 0; wi = 0; cyc = 0; stall_left = 0; fin = 0; stall_done = 0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (done) begin
        x_valid = 1'b0; w_valid = 1'b0; start = 1'b0;
        if (exp_cycles != 0) check("total_cycles", cyc, exp_cycles);
        check("argmax", argmax, exp_arg);
        check("argmax_nr", argmax_nr, exp_arg_nr);
        check("done_nr", done_nr, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        fin = 1;
      end else begin
        start   = (cyc == 1) || (cyc == extra_start);
        x_valid = (xi < IP) && (!gaps || ($urandom_range(0, 2) != 0));
        x_data  = x_valid ? x_vec[xi] : 16'($urandom);
        w_valid = (wi < W_LEN) && (!gaps || ($urandom_range(0, 2) != 0));
        w_data  = w_valid ? w_vec[wi] : 16'($urandom);
        z_ready = 1'b1;
        if (stall_left == 0 && !stall_done && z_valid && (32'(z_index) == stall_n)) stall_left = 5;
        if (stall_left > 0) begin
          z_ready = 1'b0;
          check("stall_z_valid", z_valid, 1);
          check("stall_z_data", z_data, exp_q[0]);
          check("stall_z_index", z_index, stall_n);
          check("stall_w_ready", w_ready, 0);
          stall_left--;
          if (stall_left == 0) stall_done = 1;
        end
        check("ready_exclusive", x_ready & w_ready, 0);
        if (z_valid && z_ready) begin
          check("z_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            check("z_data", z_data, exp_q.pop_front());
            check("z_data_nr", z_data_nr, exp_nr_q.pop_front());
            check("z_index", z_index, idx_q.pop_front());
          end
        end
        if (cyc == abort_cyc) begin
          rst = 1'b1;
          fin = 1;
        end
        x_hs = x_valid && x_ready;
        w_hs = w_valid && w_ready;
        @(posedge clk);
        if (x_hs) xi++;
        if (w_hs) wi++;
      end
      @(negedge clk);
    end
    check("run_finished", fin, 1);
    start = 1'b0; x_valid = 1'b0; w_valid = 1'b0; z_ready = 1'b1; rst = 1'b0;
    if (abort_cyc == 0) begin
      check("done_one_cycle", done, 0);
      check("idle_not_busy", busy, 0);
      check("argmax_held", argmax, exp_arg);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_valid = 1'b0; w_valid = 1'b0; z_ready = 1'b1;
    x_data = '0; w_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Basic network, all streams at full rate; argmax is neuron 1.
    load_basic();
    run(0, -1, 0, 0, 2'd1, 2'd1, TOTAL_CYC);

    // Three equal outputs keep the lowest index; a start mid-run is ignored.
    set_n(0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    set_n(1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    set_n(2, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    push_exp(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run(0, -1, 8, 0, 2'd0, 2'd0, TOTAL_CYC);

    // Positive and negative saturation, and a -2.0 neuron through ReLU on/off.
    set_x(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    set_n(0, 16'h0000, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    set_n(1, 16'h0000, 16'h8100, 16'h8100, 16'h8100, 16'h8100);
    set_n(2, 16'hFE00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    push_exp(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'hFE00);
    run(0, -1, 0, 0, 2'd0, 2'd0, 0);

    // Basic network with random input gaps and a 5-cycle output stall on neuron 1.
    load_basic();
    run(1, 1, 0, 0, 2'd1, 2'd1, 0);

    // Abort during the MAC phase of neuron 1, then a clean rerun.
    load_basic();
    run(0, -1, 0, 14, 2'd0, 2'd0, 0);
    check_reset_state("abort");
    exp_q.delete(); exp_nr_q.delete(); idx_q.delete();
    load_basic();
    run(0, -1, 0, 0, 2'd1, 2'd1, TOTAL_CYC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_engine.md
Name: fc_layer_engine

Overview:
- Time-multiplexed, parametrised fully-connected layer. It replaces the fully combinational FC layer with a single signed multiply-accumulate (MAC) datapath.
- Buffers one input vector, then computes each output neuron in turn from weights and biases streamed in by the DMA.
- Each result is emitted on a valid/ready stream with optional ReLU.
- Tracks the argmax across all neurons, so a classifier is built by chaining two instances, with no softmax block.

Parameters:
- WORD_SIZE, 16, data word width; signed fixed point.
- INT_SLICE, 8, integer bits including sign; FRAC = WORD_SIZE-INT_SLICE.
- IP_SIZE, 128, input vector length.
- OP_SIZE, 84, number of output neurons.
- RELU_EN, 1, 1 = clamp negative outputs to 0.
- IDX_W, $clog2(OP_SIZE), width of neuron index and argmax.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one inference; sampled only in IDLE.
- x_valid  in  1  input word valid.
- x_data  in  WORD_SIZE  input word, element 0 first.
- x_ready  out  1  engine accepts x_data.
- w_valid  in  1  weight/bias word valid.
- w_data  in  WORD_SIZE  per neuron: bias first, then IP_SIZE weights, element 0 first.
- w_ready  out  1  engine accepts w_data.
- z_valid  out  1  output neuron value valid.
- z_data  out  WORD_SIZE  activated output value.
- z_index  out  IDX_W  neuron index of z_data.
- z_ready  in  1  downstream accepts z_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last neuron is emitted.
- argmax  out  IDX_W  index of the largest z_data; valid from done until the next start.

Behaviour:
- Reset: state IDLE. x_ready, w_ready, z_valid, busy and done are 0; z_data, z_index and argmax are 0. All counters and the accumulator clear.
- Reset asserted mid-operation aborts the inference and discards all partial data; the buffered vector is not reused.
- ACC_W = 2*WORD_SIZE + $clog2(IP_SIZE) + 1. The accumulator is signed and cannot overflow.
- The input buffer is IP_SIZE x WORD_SIZE registers, indexed by counter k.
- States:
  - IDLE: start=1 -> LOAD_X with k=0. start in any other state is ignored.
  - LOAD_X: x_ready=1. Each x handshake writes buf[k] and increments k. On the handshake with k=IP_SIZE-1 -> BIAS with n=0.
  - BIAS: w_ready=1. On handshake, acc = sign_extend(w_data) << FRAC, which aligns the bias to the product scale. Then -> MAC with k=0.
  - MAC: w_ready=1. Each handshake does acc += signed(buf[k]) * signed(w_data): one MAC per cycle, stalling while w_valid=0. On the handshake with k=IP_SIZE-1 -> EMIT; the final product is included.
  - EMIT:
    - z_valid=1 and w_ready=0.
    - z_data = act(sat(acc >>> FRAC)), where >>> is an arithmetic shift (floor, no rounding) and sat clamps to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
    - act returns 0 for negative values when RELU_EN=1.
    - z_index = n.
    - z_data and z_index stay stable while z_ready=0.
    - On z handshake, update argmax: take n if n==0 or z_data > best (signed, strict), so ties keep the lower index.
    - Then go to DONE if n==OP_SIZE-1, else increment n and go to BIAS.
  - DONE: done=1 for one cycle, then -> IDLE. argmax is held.
- Throughput with all valid/ready held high:
  - LOAD_X takes IP_SIZE cycles.
  - Each neuron takes IP_SIZE+2 cycles (BIAS, IP_SIZE x MAC, EMIT).
  - DONE takes 1 cycle.
  - Total from start: 1 + IP_SIZE + OP_SIZE*(IP_SIZE+2) + 1 cycles.
- x_ready and w_ready are never high at the same time; neither is high in IDLE, EMIT or DONE.

Decomposition:
- Package fc_pkg holds:
  - the state enum (IDLE, LOAD_X, BIAS, MAC, EMIT, DONE);
  - the acc_width(word, ip) function;
  - the sat_shift function (arithmetic shift by FRAC and saturate to WORD_SIZE);
  - Q-format constants (FRAC, ONE = 1<<FRAC).
- Sub-module fc_mac_unit: accumulator register with clear/load-bias/accumulate controls and a combinational sat/ReLU output.
- The FSM, input buffer, counters and argmax stay in fc_layer_engine.

Test Plan:
- Basic, IP=4, OP=3, Q8.8, x=[0x0100,0x0200,0x0300,0x0400]:
  - n0: bias 0, w=[0x0100,0,0,0] -> 0x0100.
  - n1: bias 0x0080, w=[0,0,0,0x0100] -> 0x0480.
  - n2: bias 0, w=[0x0080,0x0080,0,0] -> 0x0180.
  - Then done=1 for one cycle, argmax=1, and the total cycle count matches the throughput formula.
- Saturation: x all 0x7F00 with w all 0x7F00 -> z_data=0x7FFF. With w all 0x8100, RELU_EN=0 -> z_data=0x8000.
- ReLU: a neuron summing to -2.0 gives z_data=0x0000 with RELU_EN=1 and 0xFE00 with RELU_EN=0.
- Backpressure:
  - z_ready low for 5 cycles in EMIT -> z_valid held, z_data/z_index unchanged, w_ready=0.
  - Random w_valid/x_valid gaps -> results identical to the no-stall run.
- Ties: all three outputs 0x0100 -> argmax=0. start pulsed while busy -> ignored, results unchanged.
- Reset mid-MAC of n1, then a new start with the basic vectors -> outputs exactly match the basic scenario, with no residue from the aborted run.
